arcade_input_mapper: RTL and testbench
======================================

Name: arcade_input_mapper

Overview:
- Generalised input front-end for arcade cores. It merges PS/2 key events, looked up through a keymap loaded at runtime, with two joystick words into one N_BTN-wide active-high button vector.
- It holds the DIP switch bytes loaded through ioctl.
- It stretches coin pulses to a minimum width.
- It sits between hps_io and the game-specific input_0..input_4 packing logic, and replaces per-core hardcoded scancode case statements.

Parameters:
- N_BTN, 16, button vector width, 1..32.
- N_DIP, 8, number of DIP bytes stored.
- KEYMAP_INDEX, 2, ioctl_index value that selects a keymap download.
- DIP_INDEX, 254, ioctl_index value that selects a DIP download.
- COIN_MASK, 16'h0400, N_BTN-bit mask of buttons that receive coin stretching.
- COIN_HOLD, 250000, minimum high time of a stretched coin bit, in clk_sys cycles (10 ms at 25 MHz).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_key  in  11  [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
- joy_0  in  N_BTN  joystick 0 buttons, active high.
- joy_1  in  N_BTN  joystick 1 buttons, active high.
- ioctl_wr  in  1  download write strobe.
- ioctl_index  in  8  download index.
- ioctl_addr  in  25  download byte address.
- ioctl_dout  in  8  download data.
- btn_out  out  N_BTN  merged buttons, active high, registered.
- dip_out  out  8*N_DIP  DIP bytes; byte k is at [8k+7:8k].
- keymap_ready  out  1  high once the keymap clear sweep has finished.

Behaviour:
- Reset (async): btn_out=0, dip_out=0, keymap_ready=0, key_state=0, all coin counters=0, old_toggle=0. The FSM enters CLEAR.
- Keymap storage: a 512x8 RAM addressed by {ext, scancode}. Entry format: [7] valid, [4:0] button index.
  - An entry whose index is >= N_BTN is ignored on lookup.
- FSM CLEAR:
  - A 9-bit counter writes 0 to every entry, addresses 0..511, one per cycle.
  - After address 511 is written, the FSM moves to RUN and keymap_ready rises on the next cycle (cycle 512 after reset release).
  - Key events and keymap writes arriving during CLEAR are dropped. DIP writes are accepted.
- FSM RUN:
  - Keymap load: on ioctl_wr && ioctl_index==KEYMAP_INDEX && ioctl_addr<512, write ioctl_dout to RAM[ioctl_addr[8:0]].
  - Address >= 512 is ignored.
- Key events:
  - Detection: a key event is detected when ps2_key[10] != old_toggle. old_toggle samples every cycle.
  - Lookup: the event latches {ext, code, pressed} and reads RAM in the following cycle. In the cycle after that, if the entry is valid and its index < N_BTN, key_state[idx] <= pressed.
  - Latency: btn_out reflects the change 3 cycles after the toggle edge is sampled.
  - Collision with a keymap write: if a keymap write occurs in the lookup cycle, the write takes the RAM and the lookup is retried in the next cycle, adding 1 cycle. Only one event is pending at a time. A second toggle arriving while one is pending overwrites the latched event; the PS/2 source guarantees spacing far greater than this.
- DIP bytes: on ioctl_wr && ioctl_index==DIP_INDEX && ioctl_addr<N_DIP, dip byte [ioctl_addr] <= ioctl_dout, visible on dip_out the next cycle. Out-of-range addresses are ignored. DIP writes are accepted in any FSM state.
- Merge: raw = key_state | joy_0 | joy_1. btn_out is registered, giving 1-cycle latency from the joystick inputs.
- Coin stretch, for each bit i with COIN_MASK[i]=1:
  - On a rising edge of raw[i], load a per-bit counter with COIN_HOLD-1.
  - btn_out[i] = raw[i] | (counter!=0). The counter decrements to 0 and holds there.
  - A new rising edge while the counter is nonzero reloads it, extending the pulse.
  - If raw[i] stays high longer than COIN_HOLD, the output follows raw[i].
  - Unmasked bits pass raw through unchanged.
- Reset mid-operation (during CLEAR, a keymap load, or an active stretch) returns every register to its reset value immediately and restarts CLEAR.

Test Plan:
- Reset release: count cycles to keymap_ready rising -> 512. Press scancode 'h14 during CLEAR -> btn_out stays 0.
- Keymap load: write addr 'h014 = 8'h84, then send a press of 'h14 (ps2_key = {~tgl,1,0,8'h14}) -> btn_out[4]=1 exactly 3 cycles later. Send a release -> btn_out[4]=0 after 3 cycles.
- Extended key and invalid entries: load addr 'h175 = 8'h83 and send ext 'h75 -> btn_out[3]=1. Send non-extended 'h75 -> no change. Load an entry 8'h9F with N_BTN=16 -> ignored.
- Collision: issue a keymap write in the same cycle as the lookup -> btn_out updates after 4 cycles, and the written entry is correct on readback via a later event.
- Coin stretch, COIN_HOLD=100 in the bench: pulse joy_0[10] for 1 cycle -> btn_out[10] is high for exactly 100 cycles. A second pulse at cycle 50 -> high until cycle 150.
- DIP load: write addrs 0..7 with 'hA0..'hA7 and addr 8 with 'hFF -> dip_out = 64'hA7A6A5A4A3A2A1A0. Assert reset mid-stream -> dip_out=0 and keymap_ready=0 immediately.

Source files
------------

// File: rtl/arcade_input_mapper.sv
// ---------------------------------------------------------------------------
// arcade_input_mapper
//   Input front-end for arcade cores. PS/2 key events are translated through
//   a runtime-loadable keymap RAM and OR-merged with two joystick words into a
//   single active-high button vector. The block also holds DIP switch bytes
//   loaded over ioctl, and stretches selected (coin) buttons to a minimum
//   high time.
//
// Ports
//   clk_sys      system clock
//   reset        asynchronous active-high reset
//   ps2_key      [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   joy_0/joy_1  joystick buttons, active high
//   ioctl_*      download port (keymap and DIP downloads)
//   btn_out      merged, registered button vector
//   dip_out      DIP bytes, byte k at [8k+7:8k]
//   keymap_ready high once the power-on keymap clear sweep has finished
// ---------------------------------------------------------------------------
module arcade_input_mapper #(
    parameter int               N_BTN        = 16,
    parameter int               N_DIP        = 8,
    parameter int               KEYMAP_INDEX = 2,
    parameter int               DIP_INDEX    = 254,
    parameter logic [N_BTN-1:0] COIN_MASK    = 16'h0400,
    parameter int               COIN_HOLD    = 250000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [10:0]          ps2_key,
    input  logic [N_BTN-1:0]     joy_0,
    input  logic [N_BTN-1:0]     joy_1,
    input  logic                 ioctl_wr,
    input  logic [7:0]           ioctl_index,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic [N_BTN-1:0]     btn_out,
    output logic [8*N_DIP-1:0]   dip_out,
    output logic                 keymap_ready
);

    localparam int CW = $clog2(COIN_HOLD + 1);

    localparam logic S_CLEAR = 1'b0;
    localparam logic S_RUN   = 1'b1;

    logic             state;
    logic [8:0]       clr_addr;

    // keymap RAM, entry: [7] valid, [4:0] button index
    logic [7:0]       ram [0:511];
    logic             ram_we;
    logic [8:0]       ram_waddr;
    logic [7:0]       ram_wdata;

    logic             old_toggle;
    logic             key_ev;
    logic             km_wr;
    logic             pending;
    logic             lookup;
    logic [8:0]       ev_addr;
    logic             ev_pressed;
    logic             rd_vld;
    logic             rd_pressed;
    logic             rd_valid;
    logic [4:0]       rd_idx;

    logic [N_BTN-1:0] key_state;
    logic [N_BTN-1:0] raw;
    logic [N_BTN-1:0] raw_prev;
    logic [N_BTN-1:0] stretched;

    logic             dip_wr;
    logic [8*N_DIP-1:0] dip_q;

    assign keymap_ready = (state == S_RUN);
    assign dip_out      = dip_q;

    // Key events and keymap writes are only honoured once the clear sweep is done.
    assign key_ev = (state == S_RUN) && (ps2_key[10] != old_toggle);
    assign km_wr  = (state == S_RUN) && ioctl_wr &&
                    (ioctl_index == 8'(KEYMAP_INDEX)) && (ioctl_addr[24:9] == '0);

    // Single-port RAM: a keymap write steals the cycle and the lookup waits.
    assign lookup    = pending && !km_wr;
    assign ram_we    = (state == S_CLEAR) || km_wr;
    assign ram_waddr = (state == S_CLEAR) ? clr_addr : ioctl_addr[8:0];
    assign ram_wdata = (state == S_CLEAR) ? 8'h00 : ioctl_dout;

    always_ff @(posedge clk_sys) begin
        if (ram_we)
            ram[ram_waddr] <= ram_wdata;
        if (lookup) begin
            rd_valid <= ram[ev_addr][7];
            rd_idx   <= ram[ev_addr][4:0];
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= S_CLEAR;
            clr_addr   <= '0;
            old_toggle <= 1'b0;
            pending    <= 1'b0;
            ev_addr    <= '0;
            ev_pressed <= 1'b0;
            rd_vld     <= 1'b0;
            rd_pressed <= 1'b0;
            key_state  <= '0;
        end else begin
            old_toggle <= ps2_key[10];

            if (state == S_CLEAR) begin
                clr_addr <= clr_addr + 9'd1;
                if (clr_addr == 9'd511)
                    state <= S_RUN;
            end

            // A new event overwrites whatever is still pending.
            if (key_ev) begin
                pending    <= 1'b1;
                ev_addr    <= ps2_key[8:0];
                ev_pressed <= ps2_key[9];
            end else if (lookup) begin
                pending <= 1'b0;
            end

            rd_vld <= lookup;
            if (lookup)
                rd_pressed <= ev_pressed;

            if (rd_vld && rd_valid && ({1'b0, rd_idx} < 6'(N_BTN))) begin
                for (int i = 0; i < N_BTN; i++)
                    if (rd_idx == 5'(i))
                        key_state[i] <= rd_pressed;
            end
        end
    end

    assign raw = key_state | joy_0 | joy_1;

    genvar g;
    generate
        for (g = 0; g < N_BTN; g++) begin : g_btn
            if (COIN_MASK[g]) begin : g_coin
                logic [CW-1:0] cnt;
                always_ff @(posedge clk_sys or posedge reset) begin
                    if (reset)
                        cnt <= '0;
                    else if (raw[g] && !raw_prev[g])
                        cnt <= CW'(COIN_HOLD - 1);
                    else if (cnt != '0)
                        cnt <= cnt - CW'(1);
                end
                assign stretched[g] = raw[g] | (cnt != '0);
            end else begin : g_pass
                assign stretched[g] = raw[g];
            end
        end
    endgenerate

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            raw_prev <= '0;
            btn_out  <= '0;
        end else begin
            raw_prev <= raw;
            btn_out  <= stretched;
        end
    end

    assign dip_wr = ioctl_wr && (ioctl_index == 8'(DIP_INDEX));

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dip_q <= '0;
        end else if (dip_wr) begin
            for (int k = 0; k < N_DIP; k++)
                if (ioctl_addr == 25'(k))
                    dip_q[8*k +: 8] <= ioctl_dout;
        end
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// ---------------------------------------------------------------------------
// tb_arcade_input_mapper
//   Directed bench for arcade_input_mapper (N_BTN=16, COIN_HOLD=100).
// ---------------------------------------------------------------------------
module tb_arcade_input_mapper;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joy_0, joy_1;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] btn_out;
    logic [63:0] dip_out;
    logic        keymap_ready;

    int n_cmp = 0;
    int n_err = 0;
    logic tgl = 1'b0;

    arcade_input_mapper #(.N_BTN(16), .N_DIP(8), .KEYMAP_INDEX(2), .DIP_INDEX(254),
                          .COIN_MASK(16'h0400), .COIN_HOLD(100)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key),
        .joy_0(joy_0), .joy_1(joy_1),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .btn_out(btn_out), .dip_out(dip_out), .keymap_ready(keymap_ready)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic km_wr(input logic [8:0] a, input logic [7:0] d);
        ioctl_wr = 1'b1; ioctl_index = 8'd2; ioctl_addr = {16'd0, a}; ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic dip_wr(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr = 1'b1; ioctl_index = 8'd254; ioctl_addr = a; ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic send_key(input logic ext, input logic [7:0] code, input logic pressed);
        tgl = ~tgl;
        ps2_key = {tgl, pressed, ext, code};
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!keymap_ready && n < 1000) begin
            tick();
            n++;
            if (n == 10) send_key(1'b0, 8'h14, 1'b1);
        end
    endtask

    initial begin
        int n;
        int cnt;

        reset = 1'b1; ps2_key = '0; joy_0 = '0; joy_1 = '0;
        ioctl_wr = 1'b0; ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
        ticks(3);
        chk("rst_btn", 64'(btn_out), 64'h0);
        chk("rst_dip", dip_out, 64'h0);
        chk("rst_ready", 64'(keymap_ready), 64'h0);

        // clear sweep length, with a key press arriving mid-sweep
        reset = 1'b0;
        wait_ready(n);
        chk("clear_cycles", 64'(n), 64'd512);
        chk("clear_key_drop", 64'(btn_out), 64'h0);
        ticks(4);
        chk("clear_key_drop_late", 64'(btn_out), 64'h0);

        // joystick merge, 1-cycle latency
        joy_0 = 16'h8000; joy_1 = 16'h0001;
        tick();
        chk("joy_merge", 64'(btn_out), 64'h8001);
        joy_0 = '0; joy_1 = '0;
        tick();
        chk("joy_clear", 64'(btn_out), 64'h0);

        // keymap press/release, 3-cycle latency
        km_wr(9'h014, 8'h84);
        send_key(1'b0, 8'h14, 1'b1);
        ticks(3);
        chk("press_early", 64'(btn_out), 64'h0);
        tick();
        chk("press_lat3", 64'(btn_out), 64'h0010);
        send_key(1'b0, 8'h14, 1'b0);
        ticks(3);
        chk("release_early", 64'(btn_out), 64'h0010);
        tick();
        chk("release_lat3", 64'(btn_out), 64'h0);

        // extended key, then the non-extended code is unmapped
        km_wr(9'h175, 8'h83);
        send_key(1'b1, 8'h75, 1'b1);
        ticks(4);
        chk("ext_press", 64'(btn_out), 64'h0008);
        send_key(1'b0, 8'h75, 1'b1);
        ticks(4);
        chk("nonext_nochange", 64'(btn_out), 64'h0008);

        // valid entry with index >= N_BTN is ignored
        km_wr(9'h015, 8'h9F);
        send_key(1'b0, 8'h15, 1'b1);
        ticks(4);
        chk("idx_oob", 64'(btn_out), 64'h0008);

        // collision: keymap write in the lookup cycle delays by one
        send_key(1'b0, 8'h14, 1'b1);
        tick();
        ioctl_wr = 1'b1; ioctl_index = 8'd2; ioctl_addr = 25'h01C; ioctl_dout = 8'h82;
        tick();
        ioctl_wr = 1'b0;
        tick();
        tick();
        chk("collide_early", 64'(btn_out), 64'h0008);
        tick();
        chk("collide_lat4", 64'(btn_out), 64'h0018);
        send_key(1'b0, 8'h1C, 1'b1);
        ticks(4);
        chk("collide_readback", 64'(btn_out), 64'h001C);

        send_key(1'b0, 8'h14, 1'b0); ticks(4);
        send_key(1'b1, 8'h75, 1'b0); ticks(4);
        send_key(1'b0, 8'h1C, 1'b0); ticks(4);
        chk("all_released", 64'(btn_out), 64'h0);

        // coin stretch: single 1-cycle pulse
        joy_0 = 16'h0400;
        tick();
        joy_0 = '0;
        chk("coin_first", 64'(btn_out), 64'h0400);
        cnt = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            cnt += int'(btn_out[10]);
        end
        chk("coin_width", 64'(cnt), 64'd100);

        // coin stretch: second pulse at +50 extends to 150
        joy_0 = 16'h0400;
        tick();
        cnt = 1;
        for (int i = 1; i <= 300; i++) begin
            joy_0 = (i == 50) ? 16'h0400 : 16'h0000;
            tick();
            cnt += int'(btn_out[10]);
        end
        joy_0 = '0;
        chk("coin_extend", 64'(cnt), 64'd150);

        // coin held longer than COIN_HOLD follows the input
        joy_0 = 16'h0400;
        ticks(150);
        chk("coin_held", 64'(btn_out), 64'h0400);
        joy_0 = '0;
        tick();
        chk("coin_held_drop", 64'(btn_out), 64'h0);

        // DIP load
        dip_wr(25'd0, 8'hA0);
        chk("dip_first", 64'(dip_out[7:0]), 64'hA0);
        for (int k = 1; k < 8; k++) dip_wr(25'(k), 8'(8'hA0 + k));
        dip_wr(25'd8, 8'hFF);
        chk("dip_all", dip_out, 64'hA7A6A5A4A3A2A1A0);

        // reset mid-stream during a stretch and a keymap write
        joy_0 = 16'h0400;
        tick();
        joy_0 = '0;
        ioctl_wr = 1'b1; ioctl_index = 8'd2; ioctl_addr = 25'h020; ioctl_dout = 8'h81;
        reset = 1'b1;
        #1;
        chk("midrst_dip", dip_out, 64'h0);
        chk("midrst_ready", 64'(keymap_ready), 64'h0);
        chk("midrst_btn", 64'(btn_out), 64'h0);
        ioctl_wr = 1'b0;
        ticks(2);
        reset = 1'b0;
        wait_ready(n);
        chk("midrst_clear_cycles", 64'(n), 64'd512);
        ticks(4);
        chk("midrst_btn_after", 64'(btn_out), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
